delay_timer: RTL and testbench
==============================

# delay_timer

Multi-channel programmable period timer, the parametrised successor of the single fixed-period delay counter. Each of `CH` independent channels counts `0..P` and pulses `sig` for one cycle at the terminal count. It exposes `flg` (still counting) and a sticky `err` (safety violation). Periods are reloaded at run time through a valid/ready port and take effect only at a channel's wrap boundary, so the counter never skips past its terminal count. It sits beside control FSMs that need timeouts and periodic strobes, and it is the formal-verification target for safety and liveness properties.

## Interface
- `CH`, 4, number of channels (1..16)
- `CBITS`, 14, counter and period width
- `DEF_PERIOD`, 15000, period loaded on reset; must be < 2^CBITS
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  CH  per-channel count enable
- `cfg_valid`  in  1  period load request
- `cfg_ready`  out  1  load accepted when `cfg_valid && cfg_ready`
- `cfg_ch`  in  $clog2(CH) (min 1)  target channel
- `cfg_period`  in  CBITS  new period P
- `sig`  out  CH  terminal count reached (`cnt >= P`)
- `flg`  out  CH  counting (`cnt < P`)
- `err`  out  CH  sticky: `cnt > P` was observed
- `cnt_o`  out  CH*CBITS  packed counters, channel 0 in LSBs

## Operation
- Per-channel state: `cnt`, `per`, `pend_val`, `pend`, `err_q`.
- `rst`:
  - `cnt=0`, `per=DEF_PERIOD`, `pend=0`, `err_q=0`.
  - Outputs after reset: `sig=0`, `flg=1`, `err=0`, `cnt_o=0`. If `DEF_PERIOD=0`, then `sig=1` and `flg=0`.
- Counter update, in priority order:
  1. `rst`
  2. `en && cnt>=per`: wrap. `cnt<=0`. If `pend`, then `per<=pend_val` and `pend<=0`.
  3. `!en && pend`: `per<=pend_val`, `cnt<=0`, `pend<=0`.
  4. `en`: `cnt<=cnt+1`.
  5. Otherwise hold.
- `sig`, `flg` and `cnt_o` are combinational from `cnt` and `per`. `err_q` sets on `cnt>per` and clears only on `rst`.
- `cfg_ready = !rst && !pend[cfg_ch]`. On accept: `pend_val<=cfg_period`, `pend<=1`.
- Arithmetic is unsigned and CBITS wide. `cnt` never exceeds `per`, so there is no overflow. `per=0` holds `cnt` at 0 with `sig` constantly high while enabled.

## Timing
- With `en` held high, the period is `per+1` cycles. `sig` is high for exactly 1 cycle per period.
- First `sig` comes `DEF_PERIOD` cycles after the first non-reset cycle.
- A load accepted in cycle t applies at the first wrap after t, never in cycle t, even if the wrap falls in cycle t. On a disabled channel the load applies at t+1.
- A second load to a channel with `pend=1` is stalled (`cfg_ready=0`) until the pending value is applied.
- Reset mid-count or mid-load discards `pend`. `rst` dominates all other inputs.

## Configuration
- `DELAY_TIMER_SVA_EN` defined: per-channel concurrent assertions are compiled in.
  - Safety: `!err` always.
  - Liveness: `(always !rst && en) implies s_nexttime always (flg s_until sig)`.
  - Handshake assumption: `cfg_valid && !cfg_ready` implies `cfg_valid` and data are stable next cycle.
- Not defined: no assertions. RTL behaviour is identical either way.

## Structure
- `delay_timer_pkg` holds:
  - `DEF_CBITS` and `DEF_PERIOD` constants.
  - `typedef logic [CBITS-1:0] period_t` (parametrised via a localparam in the module).
  - Channel-index width function.
- Sub-module `delay_timer_chan` implements one channel (counter, period, pending, err, SVA). The top generates `CH` instances and holds the cfg decode and `cfg_ready` mux.

## Test plan
- Reset, `en=1111`, default period 15000 -> `sig[i]` pulses at cycles 15000, 30001, … and `err` stays 0.
- Load ch1 with P=3 mid-count (cnt=7000) -> ch1 finishes 15000, then `sig` every 4 cycles; other channels are unaffected.
- Two back-to-back loads to ch2 -> second `cfg_valid` sees `cfg_ready=0` until the first applies at the wrap, then is accepted.
- `en[0]=0` at cnt=50, load P=10 -> next cycle `cnt=0`, `per=10`; re-enable -> `sig` 10 cycles later, and `err` never sets.
- P=0 on ch3 -> `sig[3]=1` and `flg[3]=0` continuously while enabled.
- `rst` asserted with a load pending and cnt=9 -> next cycle `cnt=0`, `per=15000`, `pend=0`, `cfg_ready=0` during `rst`.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared constants, types and helpers for the delay_timer block.
//   DEF_CBITS  - default counter/period width
//   DEF_PERIOD - default period loaded on reset
//   period_t   - period/counter word at the default width
//   ch_idx_w() - width of a channel index (at least 1 bit)
package delay_timer_pkg;

    localparam int unsigned DEF_CBITS  = 14;
    localparam int unsigned DEF_PERIOD = 15000;

    typedef logic [DEF_CBITS-1:0] period_t;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_timer_chan.sv
// delay_timer_chan: one timer channel (counter, active period, pending reload, sticky error).
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   en_i             count enable
//   load_i           accepted reload for this channel (one cycle)
//   load_period_i    period carried by the reload
//   pend_o           a reload is waiting for the next wrap (or idle cycle)
//   sig_o / flg_o    terminal count reached / still counting
//   err_o            sticky: counter was seen above the period
//   cnt_o            current count
// Optional: DELAY_TIMER_SVA_EN compiles in safety and liveness assertions.
module delay_timer_chan
    import delay_timer_pkg::*;
#(
    parameter int unsigned CBITS   = DEF_CBITS,
    parameter int unsigned DEF_PER = DEF_PERIOD
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CBITS-1:0] load_period_i,
    output logic             pend_o,
    output logic             sig_o,
    output logic             flg_o,
    output logic             err_o,
    output logic [CBITS-1:0] cnt_o
);

    typedef logic [CBITS-1:0] cnt_t;

    cnt_t cnt_q, cnt_d;
    cnt_t per_q, per_d;
    cnt_t pend_val_q, pend_val_d;
    logic pend_q, pend_d;
    logic err_q, err_d;

    always_comb begin
        cnt_d      = cnt_q;
        per_d      = per_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        err_d      = err_q | (cnt_q > per_q);

        if (en_i && (cnt_q >= per_q)) begin
            // Wrap: the only point where an enabled channel may switch period.
            cnt_d = '0;
            if (pend_q) begin
                per_d  = pend_val_q;
                pend_d = 1'b0;
            end
        end else if (!en_i && pend_q) begin
            // Idle channel takes a pending period immediately and restarts from zero.
            per_d  = pend_val_q;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (en_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        // Accept is only possible with pend_q low, so it never races the clears above.
        if (load_i) begin
            pend_val_d = load_period_i;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            per_q      <= cnt_t'(DEF_PER);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

    assign pend_o = pend_q;
    assign sig_o  = (cnt_q >= per_q);
    assign flg_o  = (cnt_q < per_q);
    assign err_o  = err_q;
    assign cnt_o  = cnt_q;

`ifdef DELAY_TIMER_SVA_EN
    a_no_err : assert property (@(posedge clk_i) disable iff (rst_i) !err_o);

    // While enabled, a counting channel keeps counting until it reaches its terminal count.
    a_live : assert property (@(posedge clk_i) disable iff (rst_i || !en_i)
        flg_o |-> (flg_o s_until sig_o));
`else
`endif

endmodule

// File: rtl/delay_timer.sv
// delay_timer: CH-channel programmable period timer with run-time period reload.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en[CH]                per-channel count enable
//   cfg_valid/cfg_ready   reload handshake; cfg_ch selects channel, cfg_period is new period
//   sig[CH]               terminal count reached
//   flg[CH]               still counting
//   err[CH]               sticky safety violation
//   cnt_o[CH*CBITS]       packed counters, channel 0 in the LSBs
// Optional: DELAY_TIMER_SVA_EN compiles in assertions and the handshake assumption.
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int unsigned CH         = 4,
    parameter int unsigned CBITS      = delay_timer_pkg::DEF_CBITS,
    parameter int unsigned DEF_PERIOD = delay_timer_pkg::DEF_PERIOD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH-1:0]                en,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [ch_idx_w(CH)-1:0]      cfg_ch,
    input  logic [CBITS-1:0]             cfg_period,
    output logic [CH-1:0]                sig,
    output logic [CH-1:0]                flg,
    output logic [CH-1:0]                err,
    output logic [CH*CBITS-1:0]          cnt_o
);

    localparam int unsigned CHW   = ch_idx_w(CH);
    localparam int unsigned NSLOT = 2 ** CHW;

    logic [CH-1:0]    pend;
    logic [CH-1:0]    load;
    logic [NSLOT-1:0] pend_ext;
    logic             accept;

    // Unused index codes (CH not a power of two) look permanently busy.
    always_comb begin
        pend_ext         = '1;
        pend_ext[CH-1:0] = pend;
    end

    assign cfg_ready = !rst && !pend_ext[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        assign load[i] = accept && (cfg_ch == CHW'(i));

        delay_timer_chan #(
            .CBITS   (CBITS),
            .DEF_PER (DEF_PERIOD)
        ) u_chan (
            .clk_i         (clk),
            .rst_i         (rst),
            .en_i          (en[i]),
            .load_i        (load[i]),
            .load_period_i (cfg_period),
            .pend_o        (pend[i]),
            .sig_o         (sig[i]),
            .flg_o         (flg[i]),
            .err_o         (err[i]),
            .cnt_o         (cnt_o[i*CBITS +: CBITS])
        );
    end

`ifdef DELAY_TIMER_SVA_EN
    m_cfg_stable : assume property (@(posedge clk) disable iff (rst)
        (cfg_valid && !cfg_ready) |=> (cfg_valid && $stable(cfg_ch) && $stable(cfg_period)));
`else
`endif

endmodule

// File: tb/tb_delay_timer.sv
module tb_delay_timer;

    localparam int CH    = 4;
    localparam int CBITS = 14;
    localparam int DEFP  = 15000;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       en;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_ch;
    logic [CBITS-1:0]    cfg_period;
    logic [CH-1:0]       sig;
    logic [CH-1:0]       flg;
    logic [CH-1:0]       err;
    logic [CH*CBITS-1:0] cnt_o;

    always #5 clk = ~clk;

    delay_timer #(
        .CH         (CH),
        .CBITS      (CBITS),
        .DEF_PERIOD (DEFP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .sig        (sig),
        .flg        (flg),
        .err        (err),
        .cnt_o      (cnt_o)
    );

    typedef struct {
        int                  cyc;
        logic [CH-1:0]       sig;
        logic [CH-1:0]       flg;
        logic [CH-1:0]       err;
        logic [CH*CBITS-1:0] cnt;
        logic                ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: plain integers following the channel rules.
    int   m_cnt[CH];
    int   m_per[CH];
    int   m_pv[CH];
    bit   m_pend[CH];
    int   cyc;
    bit   rec;
    int   sig0_t[$];
    int   sig1_t[$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want,
                         input int c);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, got, want);
        end
    endtask

    function automatic bit model_ready();
        return !rst && !m_pend[cfg_ch];
    endfunction

    // Advance the model across one rising edge using the inputs present at that edge.
    function automatic void model_step();
        bit acc;
        acc = cfg_valid && model_ready();
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[i]  = 0;
                m_per[i]  = DEFP;
                m_pend[i] = 1'b0;
            end
            cyc = 0;
            return;
        end
        cyc++;
        for (int i = 0; i < CH; i++) begin
            if (en[i] && m_cnt[i] >= m_per[i]) begin
                m_cnt[i] = 0;
                if (m_pend[i]) begin
                    m_per[i]  = m_pv[i];
                    m_pend[i] = 1'b0;
                end
            end else if (!en[i] && m_pend[i]) begin
                m_per[i]  = m_pv[i];
                m_cnt[i]  = 0;
                m_pend[i] = 1'b0;
            end else if (en[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        if (acc) begin
            m_pv[cfg_ch]   = int'(cfg_period);
            m_pend[cfg_ch] = 1'b1;
        end
    endfunction

    function automatic void publish();
        exp_t e;
        e.cyc   = cyc;
        e.ready = model_ready();
        e.err   = '0;
        for (int i = 0; i < CH; i++) begin
            e.sig[i] = (m_cnt[i] >= m_per[i]);
            e.flg[i] = (m_cnt[i] < m_per[i]);
            e.cnt[i*CBITS +: CBITS] = CBITS'(m_cnt[i]);
        end
        exp_q.push_back(e);
    endfunction

    task automatic step();
        publish();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sig", 64'(sig), 64'(e.sig), e.cyc);
                check("flg", 64'(flg), 64'(e.flg), e.cyc);
                check("err", 64'(err), 64'(e.err), e.cyc);
                check("cnt_o", 64'(cnt_o), 64'(e.cnt), e.cyc);
                check("cfg_ready", 64'(cfg_ready), 64'(e.ready), e.cyc);
                if (rec && sig[0] === 1'b1 && sig0_t.size() < 2) sig0_t.push_back(e.cyc);
                if (rec && sig[1] === 1'b1 && sig1_t.size() < 3) sig1_t.push_back(e.cyc);
            end
        end
    end

    initial begin : stim
        bit b2_first;
        bit b2_done;
        bit acc;
        bit keep;
        int guard;

        rst        = 1'b1;
        en         = '1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        rec        = 1'b0;
        b2_first   = 1'b0;
        b2_done    = 1'b0;
        for (int i = 0; i < CH; i++) m_pv[i] = 0;

        @(posedge clk);
        #1;
        model_step();
        step();
        step();

        // Default periods on all channels, ch1 reloaded mid-count, two loads to ch2.
        rst = 1'b0;
        rec = 1'b1;
        while (cyc < 30010) begin
            cfg_valid = 1'b0;
            if (cyc == 7000) begin
                cfg_valid  = 1'b1;
                cfg_ch     = 2'd1;
                cfg_period = CBITS'(3);
            end else if (cyc == 20000) begin
                cfg_valid  = 1'b1;
                cfg_ch     = 2'd2;
                cfg_period = CBITS'(5);
                b2_first   = 1'b1;
            end else if (b2_first && !b2_done) begin
                cfg_valid  = 1'b1;
                cfg_ch     = 2'd2;
                cfg_period = CBITS'(7);
                if (model_ready()) b2_done = 1'b1;
            end
            step();
        end
        cfg_valid = 1'b0;
        rec       = 1'b0;

        // Disable ch0 at cnt=50 and load P=10, then re-enable.
        guard = 0;
        while (m_cnt[0] != 50 && guard < 200) begin
            step();
            guard++;
        end
        en[0]      = 1'b0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = CBITS'(10);
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        en[0] = 1'b1;
        repeat (25) step();

        // P=0 on ch3 via an idle cycle.
        en[3]      = 1'b0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd3;
        cfg_period = '0;
        step();
        cfg_valid = 1'b0;
        step();
        en[3] = 1'b1;
        repeat (10) step();

        // Reset with a load pending on ch0 at cnt=9.
        guard = 0;
        while (m_cnt[0] != 9 && guard < 50) begin
            step();
            guard++;
        end
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = CBITS'(12);
        step();
        cfg_valid = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();

        // Randomized traffic with small periods; a stalled request is held stable.
        keep = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            rst = ($urandom_range(499) == 0);
            for (int i = 0; i < CH; i++) en[i] = ($urandom_range(9) != 0);
            if (!keep) begin
                cfg_valid  = ($urandom_range(2) == 0);
                cfg_ch     = 2'($urandom_range(CH - 1));
                cfg_period = CBITS'($urandom_range(20));
            end
            acc  = cfg_valid && model_ready();
            keep = cfg_valid && !acc;
            step();
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
        step();
        @(negedge clk);
        #1;

        check("sig0_first", 64'((sig0_t.size() > 0) ? sig0_t[0] : -1), 64'(15000), 0);
        check("sig0_second", 64'((sig0_t.size() > 1) ? sig0_t[1] : -1), 64'(30001), 0);
        check("sig1_first", 64'((sig1_t.size() > 0) ? sig1_t[0] : -1), 64'(15000), 0);
        check("sig1_second", 64'((sig1_t.size() > 1) ? sig1_t[1] : -1), 64'(15004), 0);
        check("sig1_third", 64'((sig1_t.size() > 2) ? sig1_t[2] : -1), 64'(15008), 0);
        check("drain", 64'(exp_q.size()), 64'(0), cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
